rs_operand_wakeup: RTL and testbench
====================================

// Module: rs_operand_wakeup
// PURPOSE
//  Per-entry source-operand wakeup table for one reservation-station operand slot.
//  Tracks each entry's producer tag against 10 FU result-tag broadcasts.
//  On issue, emits the registered fuFwd/fuuFwd select codes consumed by the downstream operand forward-mux stage.
//  Code k (0..9) selects FUk; code 4'hf selects the register-file/old data.
// PARAMETERS
//  ENTRIES    8  number of RS entries (power of 2, 2..32)
//  TAG_WIDTH  9  physical register tag width
//  IDX_W      $clog2(ENTRIES)  entry index width (derived, not overridden)
// PORTS
//  clk           in   1              clock
//  rst           in   1              synchronous reset, active-high
//  flush         in   1              discard all entries
//  alloc_en      in   1              write entry alloc_idx this cycle
//  alloc_idx     in   IDX_W          entry to allocate
//  alloc_tag     in   TAG_WIDTH      producer tag of operand
//  alloc_ready   in   1              operand already in register file
//  fu_tag        in   10*TAG_WIDTH   FU result tags; FUk at [k*TAG_WIDTH +: TAG_WIDTH]
//  fu_vld        in   10             tag broadcast valid per FU
//  fu_cancel     in   10             speculative cancel per FU (RS_WAKEUP_SPEC_CANCEL_EN only)
//  issue_en      in   1              issue request for entry issue_idx
//  issue_idx     in   IDX_W          entry being issued
//  entry_valid   out  ENTRIES        registered entry-occupied bits
//  entry_ready   out  ENTRIES        combinational: valid and operand obtainable this cycle
//  issue_vld     out  1              registered: issue accepted last cycle
//  issue_fuFwd   out  4              registered select code: current-cycle FU bus
//  issue_fuuFwd  out  4              registered select code: FU bus delayed one cycle
// BEHAVIOUR
//  - Timing contract: a tag broadcast in cycle t carries data on FUk in t+1 and on FUk_reg in t+2.
//    From t+3 onward the data is read from the register file.
//  - Per-entry state (registered): valid, tag, st in {WAIT, FWD1, RF}, fu_idx[3:0].
//  - match_i[k] = fu_vld[k] & (fu_tag[k] == tag_i).
//    If several k match, the lowest k wins; multiple matches are illegal, and the bench flags them.
//  - WAIT -> FWD1 when any match_i: fu_idx <= k.
//  - FWD1 -> RF unconditionally on the next cycle.
//  - RF holds until the entry is freed.
//  - entry_ready[i] = valid_i & (st_i != WAIT | |match_i).
//  - Issue (issue_en, entry x): outputs are registered, so latency is 1 cycle.
//     WAIT + match k this cycle  -> fuFwd=k,    fuuFwd=f
//     FWD1                       -> fuFwd=f,    fuuFwd=fu_idx
//     RF                         -> fuFwd=f,    fuuFwd=f
//     not ready / entry invalid  -> issue_vld=0, codes=f; the entry is kept
//  - An accepted issue sets issue_vld<=1 and clears valid_x.
//  - When issue_en=0, issue_vld<=0 and codes<=f.
//  - Alloc: valid<=1, tag<=alloc_tag, st<=RF if alloc_ready.
//    If not alloc_ready: st<=FWD1 (fu_idx=k) when alloc_tag matches a broadcast the same cycle, else WAIT.
//  - Alloc and issue to the same idx in one cycle:
//     the issue is evaluated on the old contents;
//     the alloc write wins for the next state (entry stays valid).
//  - flush: all valid<=0 and issue_vld<=0 next cycle; alloc/issue in that cycle are ignored.
//  - Reset: entry_valid=0, all st=RF, issue_vld=0, issue_fuFwd=4'hf, issue_fuuFwd=4'hf.
//    Reset applies mid-operation as well.
//  - FU9 uses code 4'd9 only; codes 10..14 are never generated.
// CONFIGURATION
//  RS_WAKEUP_SPEC_CANCEL_EN defined:
//   - An entry in FWD1 with fu_cancel[fu_idx]=1 returns to WAIT instead of RF.
//   - An issue of such an entry in that cycle is rejected (issue_vld=0, codes f, entry kept).
//   - A WAIT match whose FU is cancelled in the same cycle is ignored.
//  Not defined: the fu_cancel port exists but is ignored; FWD1 always goes to RF.
// TESTING
//  - Reset, then alloc idx2 tag=0x15 ready=1, issue idx2 next cycle
//    -> issue_vld=1, fuFwd=f, fuuFwd=f; entry_valid[2]=0.
//  - Alloc idx0 tag=0x33 not ready; cycle 5 fu_vld[3]=1 fu_tag3=0x33 with issue idx0 in cycle 5
//    -> cycle 6: issue_vld=1, fuFwd=3, fuuFwd=f.
//  - Same as above, but issue in cycle 6 -> fuuFwd=3, fuFwd=f.
//    Issue in cycle 7 or later -> both f.
//  - Issue an unwoken WAIT entry (tag 0x40, no broadcast)
//    -> issue_vld=0, codes f, entry_valid stays 1; a later FU9 match gives fuFwd=9.
//  - Alloc with a same-cycle FU7 match, then issue the next cycle -> fuuFwd=7.
//    Flush while 4 entries are valid -> entry_valid=0 next cycle.
//  - With RS_WAKEUP_SPEC_CANCEL_EN: entry woken by FU5, fu_cancel[5] the next cycle
//    -> entry_ready=0; issue rejected; a re-broadcast then wakes it again.

Source files
------------

// File: rtl/rs_operand_wakeup.sv
// Operand wakeup table for one reservation-station source slot: tracks producer tags
// against 10 FU broadcasts and emits registered forward-mux selects on issue.
// Optional speculative cancel support: define RS_WAKEUP_SPEC_CANCEL_EN.
module rs_operand_wakeup #(
  parameter int ENTRIES   = 8,
  parameter int TAG_WIDTH = 9,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_en,
  input  logic [IDX_W-1:0]          alloc_idx,
  input  logic [TAG_WIDTH-1:0]      alloc_tag,
  input  logic                      alloc_ready,
  input  logic [10*TAG_WIDTH-1:0]   fu_tag,
  input  logic [9:0]                fu_vld,
  input  logic [9:0]                fu_cancel,
  input  logic                      issue_en,
  input  logic [IDX_W-1:0]          issue_idx,
  output logic [ENTRIES-1:0]        entry_valid,
  output logic [ENTRIES-1:0]        entry_ready,
  output logic                      issue_vld,
  output logic [3:0]                issue_fuFwd,
  output logic [3:0]                issue_fuuFwd
);

  typedef enum logic [1:0] {ST_WAIT, ST_FWD1, ST_RF} st_t;

  st_t                  st_q   [ENTRIES];
  st_t                  st_d   [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_q  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_d  [ENTRIES];
  logic [3:0]           idx_q  [ENTRIES];
  logic [3:0]           idx_d  [ENTRIES];
  logic [3:0]           hit_k  [ENTRIES];
  logic [ENTRIES-1:0]   valid_q, valid_d, hit, cancel;
  logic [9:0]           live;
  logic                 alloc_hit;
  logic [3:0]           alloc_k;
  logic                 iss_ok;
  logic [3:0]           fwd_d, fuu_d;

  // Lowest-numbered matching FU wins; 4'hf means no match.
  function automatic logic [3:0] first_k(input logic [9:0] m);
    first_k = 4'hf;
    for (int k = 9; k >= 0; k--) if (m[k]) first_k = 4'(k);
  endfunction

  function automatic logic [9:0] match_vec(input logic [TAG_WIDTH-1:0] t,
                                           input logic [10*TAG_WIDTH-1:0] tags,
                                           input logic [9:0] vld);
    for (int k = 0; k < 10; k++)
      match_vec[k] = vld[k] & (tags[k*TAG_WIDTH +: TAG_WIDTH] == t);
  endfunction

`ifdef RS_WAKEUP_SPEC_CANCEL_EN
  assign live = fu_vld & ~fu_cancel;
`else
  logic unused_cancel;
  assign unused_cancel = ^fu_cancel;
  assign live = fu_vld;
`endif

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      hit_k[i] = first_k(match_vec(tag_q[i], fu_tag, live));
      hit[i]   = (hit_k[i] != 4'hf);
`ifdef RS_WAKEUP_SPEC_CANCEL_EN
      cancel[i] = (st_q[i] == ST_FWD1) & fu_cancel[idx_q[i]];
`else
      cancel[i] = 1'b0;
`endif
      entry_ready[i] = valid_q[i] & ((st_q[i] == ST_WAIT) ? hit[i] : ~cancel[i]);
    end
    alloc_k   = first_k(match_vec(alloc_tag, fu_tag, live));
    alloc_hit = (alloc_k != 4'hf);
  end

  // Issue is judged on the pre-update contents of the addressed entry.
  always_comb begin
    iss_ok = issue_en & ~flush & entry_ready[issue_idx];
    fwd_d  = 4'hf;
    fuu_d  = 4'hf;
    if (iss_ok) begin
      case (st_q[issue_idx])
        ST_WAIT: fwd_d = hit_k[issue_idx];
        ST_FWD1: fuu_d = idx_q[issue_idx];
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      st_d[i]    = st_q[i];
      idx_d[i]   = idx_q[i];
      case (st_q[i])
        ST_WAIT: if (hit[i]) begin
          st_d[i]  = ST_FWD1;
          idx_d[i] = hit_k[i];
        end
        ST_FWD1: st_d[i] = cancel[i] ? ST_WAIT : ST_RF;
        default: ;
      endcase
      if (iss_ok && issue_idx == IDX_W'(i)) valid_d[i] = 1'b0;
      if (alloc_en && !flush && alloc_idx == IDX_W'(i)) begin
        valid_d[i] = 1'b1;
        tag_d[i]   = alloc_tag;
        if (alloc_ready) begin
          st_d[i] = ST_RF;
        end else if (alloc_hit) begin
          st_d[i]  = ST_FWD1;
          idx_d[i] = alloc_k;
        end else begin
          st_d[i] = ST_WAIT;
        end
      end
      if (flush) valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      issue_vld    <= 1'b0;
      issue_fuFwd  <= 4'hf;
      issue_fuuFwd <= 4'hf;
      for (int i = 0; i < ENTRIES; i++) begin
        st_q[i]  <= ST_RF;
        tag_q[i] <= '0;
        idx_q[i] <= 4'hf;
      end
    end else begin
      valid_q      <= valid_d;
      issue_vld    <= iss_ok;
      issue_fuFwd  <= fwd_d;
      issue_fuuFwd <= fuu_d;
      for (int i = 0; i < ENTRIES; i++) begin
        st_q[i]  <= st_d[i];
        tag_q[i] <= tag_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign entry_valid = valid_q;

endmodule

// File: tb/tb_rs_operand_wakeup.sv
// Directed bench for rs_operand_wakeup: wakeup timing, forward-select codes,
// alloc/issue collisions, flush and reset. Cancel steps need RS_WAKEUP_SPEC_CANCEL_EN.
module tb_rs_operand_wakeup;
  localparam int TW = 9;

  logic         clk = 1'b0;
  logic         rst, flush, alloc_en, alloc_ready, issue_en;
  logic [2:0]   alloc_idx, issue_idx;
  logic [TW-1:0] alloc_tag;
  logic [10*TW-1:0] fu_tag;
  logic [9:0]   fu_vld, fu_cancel;
  logic [7:0]   entry_valid, entry_ready;
  logic         issue_vld;
  logic [3:0]   issue_fuFwd, issue_fuuFwd;
  int           checks = 0;
  int           errors = 0;

  rs_operand_wakeup #(.ENTRIES(8), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en), .alloc_idx(alloc_idx),
    .alloc_tag(alloc_tag), .alloc_ready(alloc_ready), .fu_tag(fu_tag), .fu_vld(fu_vld),
    .fu_cancel(fu_cancel), .issue_en(issue_en), .issue_idx(issue_idx),
    .entry_valid(entry_valid), .entry_ready(entry_ready), .issue_vld(issue_vld),
    .issue_fuFwd(issue_fuFwd), .issue_fuuFwd(issue_fuuFwd)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flush = 0; alloc_en = 0; alloc_idx = 0; alloc_tag = 0; alloc_ready = 0;
    fu_tag = '0; fu_vld = '0; fu_cancel = '0; issue_en = 0; issue_idx = 0;
  endtask

  // Advance one clock; inputs return to idle just after the edge.
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic alloc(input logic [2:0] idx, input logic [TW-1:0] t, input logic rdy);
    alloc_en = 1; alloc_idx = idx; alloc_tag = t; alloc_ready = rdy;
  endtask

  task automatic bcast(input int k, input logic [TW-1:0] t);
    fu_vld[k] = 1'b1;
    fu_tag[k*TW +: TW] = t;
  endtask

  task automatic issue(input logic [2:0] idx);
    issue_en = 1; issue_idx = idx;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_issue(input string name, input logic v, input logic [3:0] f, input logic [3:0] u);
    chk({name, "_vld"}, 32'(issue_vld), 32'(v));
    chk({name, "_fuFwd"}, 32'(issue_fuFwd), 32'(f));
    chk({name, "_fuuFwd"}, 32'(issue_fuuFwd), 32'(u));
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_valid", 32'(entry_valid), 32'h0);
    chk("reset_ready", 32'(entry_ready), 32'h0);
    chk_issue("reset", 1'b0, 4'hf, 4'hf);

    // Ready-at-alloc entry issues with register-file codes.
    alloc(3'd2, 9'h015, 1'b1); tick();
    chk("alloc2_valid", 32'(entry_valid), 32'h04);
    chk("alloc2_ready", 32'(entry_ready), 32'h04);
    issue(3'd2); tick();
    chk_issue("rf_issue", 1'b1, 4'hf, 4'hf);
    chk("rf_issue_cleared", 32'(entry_valid), 32'h00);
    tick();
    chk("idle_issue_vld", 32'(issue_vld), 32'h0);

    // Issue in the broadcast cycle takes the current FU bus.
    alloc(3'd0, 9'h033, 1'b0); tick();
    chk("wait_not_ready", 32'(entry_ready[0]), 32'h0);
    bcast(3, 9'h033); issue(3'd0); #1;
    chk("wait_match_ready", 32'(entry_ready[0]), 32'h1);
    tick();
    chk_issue("t_plus0", 1'b1, 4'h3, 4'hf);

    // Issue one cycle after the broadcast takes the delayed bus.
    alloc(3'd0, 9'h033, 1'b0); tick();
    bcast(3, 9'h033); tick();
    issue(3'd0); tick();
    chk_issue("t_plus1", 1'b1, 4'hf, 4'h3);

    // Two cycles after the broadcast the data sits in the register file.
    alloc(3'd1, 9'h033, 1'b0); tick();
    bcast(3, 9'h033); tick();
    tick();
    issue(3'd1); tick();
    chk_issue("t_plus2", 1'b1, 4'hf, 4'hf);

    // Unwoken entry is rejected and kept; wrong tag does not wake it; FU9 does.
    alloc(3'd3, 9'h040, 1'b0); tick();
    issue(3'd3); tick();
    chk_issue("unwoken", 1'b0, 4'hf, 4'hf);
    chk("unwoken_kept", 32'(entry_valid), 32'h08);
    bcast(2, 9'h041); #1;
    chk("tag_mismatch", 32'(entry_ready[3]), 32'h0);
    tick();
    bcast(9, 9'h040); issue(3'd3); tick();
    chk_issue("fu9_wake", 1'b1, 4'h9, 4'hf);

    // Broadcast matching in the alloc cycle lands the entry in FWD1.
    alloc(3'd4, 9'h077, 1'b0); bcast(7, 9'h077); tick();
    chk("alloc_fwd1_ready", 32'(entry_ready[4]), 32'h1);
    issue(3'd4); tick();
    chk_issue("alloc_fu7", 1'b1, 4'hf, 4'h7);

    // Same-index alloc and issue: issue sees old RF entry, alloc wins next state.
    alloc(3'd5, 9'h020, 1'b1); tick();
    alloc(3'd5, 9'h010, 1'b0); issue(3'd5); tick();
    chk_issue("collide", 1'b1, 4'hf, 4'hf);
    chk("collide_valid", 32'(entry_valid), 32'h20);
    chk("collide_ready", 32'(entry_ready), 32'h00);

    // Flush with four valid entries drops everything, including that cycle's alloc/issue.
    alloc(3'd0, 9'h001, 1'b1); tick();
    alloc(3'd1, 9'h002, 1'b1); tick();
    alloc(3'd2, 9'h003, 1'b1); tick();
    chk("pre_flush_valid", 32'(entry_valid), 32'h27);
    flush = 1; alloc(3'd7, 9'h004, 1'b1); issue(3'd0); tick();
    chk("flush_valid", 32'(entry_valid), 32'h00);
    chk_issue("flush", 1'b0, 4'hf, 4'hf);

    // Reset asserted mid-operation.
    alloc(3'd3, 9'h005, 1'b1); tick();
    issue(3'd0); tick();
    rst = 1; issue(3'd3); tick();
    rst = 0;
    chk("midrst_valid", 32'(entry_valid), 32'h00);
    chk_issue("midrst", 1'b0, 4'hf, 4'hf);

`ifdef RS_WAKEUP_SPEC_CANCEL_EN
    // FU5 wakeup cancelled the following cycle, then re-broadcast.
    alloc(3'd0, 9'h055, 1'b0); tick();
    bcast(5, 9'h055); tick();
    fu_cancel[5] = 1'b1; issue(3'd0); #1;
    chk("cancel_ready", 32'(entry_ready[0]), 32'h0);
    tick();
    chk_issue("cancel_issue", 1'b0, 4'hf, 4'hf);
    chk("cancel_kept", 32'(entry_valid), 32'h01);
    bcast(5, 9'h055); issue(3'd0); tick();
    chk_issue("rewake", 1'b1, 4'h5, 4'hf);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
